// File: rtl/uart_rx_pkg.sv
// Shared UART constants: clock/baud derivation and the 3-bit state encodings.
// Optional even-parity receive is enabled with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

  localparam int CPU_CLK           = 100_000_000;
  localparam int UART_BAUD_RATE    = 576_000;
  localparam int UART_CLKS_PER_BIT = (CPU_CLK + UART_BAUD_RATE / 2) / UART_BAUD_RATE;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE   = 3'd0;
  localparam uart_state_t S_START  = 3'd1;
  localparam uart_state_t S_DATA   = 3'd2;
  localparam uart_state_t S_PARITY = 3'd3;
  localparam uart_state_t S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_serial,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], rx_serial};
  end

  assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined): mid-bit sampling,
// LSB-first assembly, 1-entry valid/ready holding register, 1-cycle error pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] byte_out,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  uart_state_t   state, next_state;
  logic          rx_s, rx_d;
  logic [CW-1:0] clk_count;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_r;
  logic          tick, stop_tick, fall, par_bad;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_s      (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (fall) next_state = S_START;
      S_START: if (tick) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) next_state = S_STOP;
`endif
      S_STOP:  if (tick) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = (state != S_IDLE);
    fall      = rx_d & ~rx_s;
    tick      = rx_busy && (clk_count == '0);
    stop_tick = (state == S_STOP) && tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_d      <= 1'b1;
      clk_count <= '0;
      bit_idx   <= '0;
      shift_r   <= '0;
      rd_valid  <= 1'b0;
      byte_out  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_d      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (!rx_busy) begin
        if (fall) clk_count <= HALF;
      end else if (tick) begin
        clk_count <= FULL;
      end else begin
        clk_count <= clk_count - ONE;
      end

      if (state == S_START && tick) bit_idx <= '0;
      if (state == S_DATA && tick) begin
        shift_r <= {rx_s, shift_r[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      // A delivery may land in the same cycle the previous byte is being read.
      if (stop_tick && !par_bad) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (!rd_valid || rd_ready) begin
          byte_out <= shift_r;
          rd_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_tick & par_bad;
      if (state == S_START)
        par_bad <= 1'b0;
      else if (state == S_PARITY && tick)
        par_bad <= ^{shift_r, rx_s};
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx against a frame-level event model.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NSLOTS  = 10;
  localparam int EXP_LAT = 171;
`else
  localparam int NSLOTS  = 9;
  localparam int EXP_LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rd_ready = 1'b1;
  logic       rd_valid, frame_err, overrun, parity_err, rx_busy;
  logic [7:0] byte_out;

  uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .byte_out   (byte_out),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame outcomes: kind 0 = good byte, 1 = framing error, 2 = parity error.
  typedef struct {int at; int kind; logic [7:0] b;} ev_t;
  ev_t evq[$];

  logic       mv = 1'b0;
  logic [7:0] mb = 8'h00;
  logic       prev_ready = 1'b0, prev_rst = 1'b1, last_valid = 1'b0;
  int rise_cyc = 0, rise_cnt = 0, valid_cycles = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [7:0] rise_byte = 8'h00;

  always @(negedge clk) begin
    ev_t  ev;
    logic efe, eov, epe, hs, deliver;
    efe = 1'b0; eov = 1'b0; epe = 1'b0; deliver = 1'b0;
    if (prev_rst) begin
      mv = 1'b0; mb = 8'h00;
      evq.delete();
      check("reset_busy", rx_busy, 0);
    end else begin
      hs = mv & prev_ready;
      while (evq.size() > 0 && evq[0].at < cyc) begin
        ev = evq.pop_front();
        check("event_missed", ev.at, cyc);
      end
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          0: if (!mv || hs) deliver = 1'b1; else eov = 1'b1;
          1: efe = 1'b1;
          default: epe = 1'b1;
        endcase
        if (deliver) begin mv = 1'b1; mb = ev.b; end
        else if (hs) mv = 1'b0;
      end else if (hs) begin
        mv = 1'b0;
      end
    end
    check("rd_valid", rd_valid, mv);
    check("byte_out", byte_out, mb);
    check("frame_err", frame_err, efe);
    check("overrun", overrun, eov);
    check("parity_err", parity_err, epe);
    if (rd_valid && !last_valid) begin rise_cyc = cyc; rise_cnt++; rise_byte = byte_out; end
    if (rd_valid) valid_cycles++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
    last_valid = rd_valid;
    prev_ready = rd_ready;
    prev_rst   = rst;
  end

  int rdy_mode = 1;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int last_k = 0;

  task automatic drive_bit(logic v, int n);
    @(posedge clk); #1;
    rx_serial = v;
    repeat (n - 1) @(posedge clk);
  endtask

  function automatic logic ep(logic [7:0] b);
    return ^b;
  endfunction

  task automatic send_frame(logic [7:0] b, logic stop, logic par);
    int kind;
    @(posedge clk); #1;
    rx_serial = 1'b0;
    last_k = cyc;
    kind = stop ? 0 : 1;
`ifdef UART_RX_PARITY_EN
    if (^{b, par}) kind = 2;
`endif
    evq.push_back('{last_k + 4 + H + NSLOTS * C, kind, b});
    repeat (C - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], C);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, C);
`endif
    drive_bit(stop, C);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r0, f0, o0, p0, v0, gap;
    logic [7:0] b;
    logic stop, par, prev_stop;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_rx_busy", rx_busy, 0);
    drive_bit(1'b1, 5);

    // Single good byte with the consumer always ready.
    r0 = rise_cnt; v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    send_frame(8'hA5, 1'b1, ep(8'hA5));
    drive_bit(1'b1, 10);
    check("a5_latency", rise_cyc - last_k, EXP_LAT);
    check("a5_byte", rise_byte, 8'hA5);
    check("a5_rises", rise_cnt - r0, 1);
    check("a5_valid_cycles", valid_cycles - v0, 1);
    check("a5_no_errors", (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0), 0);

    // Glitch shorter than half a bit.
    r0 = rise_cnt;
    drive_bit(1'b0, 4);
    @(posedge clk); #1 rx_serial = 1'b1;
    check("false_start_busy_high", rx_busy, 1);
    repeat (8) @(posedge clk); #1;
    check("false_start_busy_low", rx_busy, 0);
    drive_bit(1'b1, 20);
    check("false_start_no_byte", rise_cnt - r0, 0);

    // Bad stop bit, then the line stays low (break).
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, ep(8'h3C));
    drive_bit(1'b0, 60);
    check("break_frame_err", fe_cnt - f0, 1);
    check("break_no_byte", rise_cnt - r0, 0);
    check("break_idle", rx_busy, 0);
    drive_bit(1'b1, 10);

    // Holding register full: second byte overruns.
    rdy_mode = 0;
    drive_bit(1'b1, 3);
    r0 = rise_cnt; o0 = ov_cnt;
    send_frame(8'h11, 1'b1, ep(8'h11));
    send_frame(8'h22, 1'b1, ep(8'h22));
    drive_bit(1'b1, 10);
    check("ovr_held_valid", rd_valid, 1);
    check("ovr_held_byte", byte_out, 8'h11);
    check("ovr_pulse", ov_cnt - o0, 1);
    check("ovr_rises", rise_cnt - r0, 1);
    rdy_mode = 1;
    drive_bit(1'b1, 4);
    check("ovr_drained", rd_valid, 0);
    check("ovr_byte_kept", byte_out, 8'h11);

    // Reset mid-data of 8'hF0 (low start and low data bits), then a clean frame.
    r0 = rise_cnt;
    drive_bit(1'b0, C);
    drive_bit(1'b0, 2 * C + 5);
    @(posedge clk); #1;
    rst = 1'b1; rx_serial = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_valid", rd_valid, 0);
    drive_bit(1'b1, 10);
    send_frame(8'h5A, 1'b1, ep(8'h5A));
    drive_bit(1'b1, 10);
    check("post_rst_rises", rise_cnt - r0, 1);
    check("post_rst_byte", rise_byte, 8'h5A);

`ifdef UART_RX_PARITY_EN
    r0 = rise_cnt; p0 = pe_cnt;
    send_frame(8'h03, 1'b1, 1'b1);
    drive_bit(1'b1, 10);
    check("par_bad_pulse", pe_cnt - p0, 1);
    check("par_bad_no_byte", rise_cnt - r0, 0);
    send_frame(8'h03, 1'b1, 1'b0);
    drive_bit(1'b1, 10);
    check("par_ok_byte", rise_byte, 8'h03);
    check("par_ok_rises", rise_cnt - r0, 1);
`endif

    // Random traffic with a randomly stalling consumer.
    rdy_mode = 2;
    prev_stop = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      par  = ep(b) ^ ($urandom_range(0, 5) == 0);
      gap  = $urandom_range(prev_stop ? 0 : 3, 12);
      if (gap > 0) drive_bit(1'b1, gap);
      if ($urandom_range(0, 9) == 0) begin
        drive_bit(1'b0, $urandom_range(1, 6));
        drive_bit(1'b1, 14);
      end
      send_frame(b, stop, par);
      prev_stop = stop;
    end
    rdy_mode = 1;
    drive_bit(1'b1, 250);
    check("random_queue_empty", evq.size(), 0);
    check("random_drained", rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
